// File: rtl/truth_table_sweeper.sv
// Walks every input pattern of a small combinational block, holds each one for SETTLE+1
// cycles, then records the response in a result table and keeps a ones count per output.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic [N_IN-1:0]           drv_o,
  input  logic [N_OUT-1:0]          f_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [N_OUT*(N_IN+1)-1:0] ones_o,
  input  logic [N_IN-1:0]           rd_addr_i,
  output logic [N_OUT-1:0]          rd_data_o
);
  localparam int DEPTH = 1 << N_IN;
  localparam int OW    = N_IN + 1;
  localparam int CW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST     = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [N_IN-1:0]         drv_q, drv_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [N_OUT*OW-1:0]     ones_q, ones_d;
  logic [N_OUT-1:0]        table_q [DEPTH];
  logic [N_OUT-1:0]        rd_data_q;
  logic                    capture;

  // The last cycle of each pattern's settle window is the sampling cycle.
  assign capture = (state_q == DRIVE) && (cnt_q == SETTLE_C);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = DRIVE;
      DRIVE:      if (capture && drv_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    drv_d  = drv_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    ones_d = ones_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          drv_d  = '0;
          cnt_d  = '0;
          ones_d = '0;
          done_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      DRIVE: begin
        if (!capture) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          for (int k = 0; k < N_OUT; k++)
            ones_d[k*OW +: OW] = ones_q[k*OW +: OW] + OW'(f_i[k]);
          if (drv_q == LAST) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            drv_d = drv_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drv_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ones_q <= '0;
    end else begin
      drv_q  <= drv_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ones_q <= ones_d;
    end
  end

  // Table lives in flops because reset must clear every entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                    table_q[gi] <= '0;
      else if (capture && drv_q == N_IN'(gi))       table_q[gi] <= f_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= table_q[rd_addr_i];
  end

  assign drv_o     = drv_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ones_o    = ones_q;
  assign rd_data_o = rd_data_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a SETTLE=2 instance plus a SETTLE=0 instance.
module tb_truth_table_sweeper;
  localparam int N_IN = 4, N_OUT = 3, OW = N_IN + 1;
  localparam logic [N_OUT*OW-1:0] ONES_888 = {5'd8, 5'd8, 5'd8};
  localparam logic [N_OUT*OW-1:0] ONES_BB  = {5'd5, 5'd7, 5'd9};

  typedef struct {
    logic [N_OUT*OW-1:0] ones;
    int                  lat;
  } sweep_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic                 rst = 0, start, start0, rd_req, rd_vld = 0;
  logic [N_IN-1:0]      drv, drv0, rd_addr, rd_addr0;
  logic [N_OUT-1:0]     f, f0, rd_data, rd_data0;
  logic                 busy, done, busy0, done0;
  logic [N_OUT*OW-1:0]  ones, ones0;
  int                   mode;
  int                   cyc = 0, s_cyc = 0, s_cyc0 = 0;
  int                   errors = 0, checks = 0;
  sweep_t               sq[$], sq0[$];
  logic [N_OUT-1:0]     rq[$];
  logic                 done_prev = 0, done0_prev = 0;

  // Stand-in for the breadboard block: f0 has 9 ones, f1 7, f2 5.
  function automatic logic [2:0] bb(input logic [3:0] p);
    case (p)
      4'd0: return 3'b000;  4'd1: return 3'b001;  4'd2: return 3'b010;  4'd3: return 3'b011;
      4'd4: return 3'b000;  4'd5: return 3'b001;  4'd6: return 3'b011;  4'd7: return 3'b001;
      4'd8: return 3'b100;  4'd9: return 3'b101;  4'd10: return 3'b010; 4'd11: return 3'b011;
      4'd12: return 3'b100; 4'd13: return 3'b101; 4'd14: return 3'b010; default: return 3'b111;
    endcase
  endfunction

  always_comb begin
    case (mode)
      0:       f = drv[2:0];
      1:       f = bb(drv);
      default: f = ~drv[2:0];
    endcase
  end
  assign f0 = drv0[2:0];
  assign rd_addr0 = '0;

  truth_table_sweeper #(.N_IN(4), .N_OUT(3), .SETTLE(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .drv_o(drv), .f_i(f), .busy_o(busy),
    .done_o(done), .ones_o(ones), .rd_addr_i(rd_addr), .rd_data_o(rd_data));

  truth_table_sweeper #(.N_IN(4), .N_OUT(3), .SETTLE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .drv_o(drv0), .f_i(f0), .busy_o(busy0),
    .done_o(done0), .ones_o(ones0), .rd_addr_i(rd_addr0), .rd_data_o(rd_data0));

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitors: sweep completion and table readback, checked against queued expectations.
  always @(negedge clk) begin
    sweep_t e;
    if (done === 1'b1 && done_prev === 1'b0) begin
      if (sq.size() == 0) check("sweep_expected", sq.size(), 1);
      else begin
        e = sq.pop_front();
        check("sweep_ones", ones, e.ones);
        check("sweep_latency", cyc - s_cyc - 1, e.lat);
      end
    end
    done_prev = done;
    if (done0 === 1'b1 && done0_prev === 1'b0) begin
      if (sq0.size() == 0) check("sweep0_expected", sq0.size(), 1);
      else begin
        e = sq0.pop_front();
        check("sweep0_ones", ones0, e.ones);
        check("sweep0_latency", cyc - s_cyc0 - 1, e.lat);
      end
    end
    done0_prev = done0;
    if (rd_vld) begin
      if (rq.size() == 0) check("read_expected", rq.size(), 1);
      else check("rd_data", rd_data, rq.pop_front());
    end
  end

  task automatic do_start(input logic [N_OUT*OW-1:0] exp_ones, input int lat);
    @(negedge clk);
    start = 1;
    s_cyc = cyc;
    sq.push_back('{exp_ones, lat});
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_start0(input logic [N_OUT*OW-1:0] exp_ones, input int lat);
    @(negedge clk);
    start0 = 1;
    s_cyc0 = cyc;
    sq0.push_back('{exp_ones, lat});
    @(negedge clk);
    start0 = 0;
  endtask

  task automatic rd(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] e);
    rd_addr = a;
    rd_req  = 1;
    rq.push_back(e);
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1);
  endtask

  initial begin
    int n;
    start = 0; start0 = 0; rd_addr = 0; rd_req = 0; mode = 0;
    #1 rst = 1;
    #1;
    check("rst_drv", drv, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_drv0", drv0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Sweep with f = drv[2:0]: each pattern held 3 cycles.
    do_start(ONES_888, 48);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 48; k++) begin
      check("t1_drv", drv, k / 3);
      @(negedge clk);
    end
    wait_done("t1_done");
    for (int i = 0; i < 16; i++) rd(4'(i), 3'(i));
    @(negedge clk);

    // Sweep with f = ~drv[2:0]: stale entry visible until its pattern is captured.
    mode = 2;
    do_start(ONES_888, 48);
    repeat (20) @(negedge clk);
    rd(4'd12, 3'b100);
    @(negedge clk);
    wait_done("t6_done");
    rd(4'd12, 3'b011);
    rd(4'd0, 3'b111);
    @(negedge clk);

    // Breadboard stand-in.
    mode = 1;
    do_start(ONES_BB, 48);
    wait_done("t2_done");
    rd(4'd15, 3'b111);
    rd(4'd0, 3'b000);
    rd(4'd6, 3'b011);
    @(negedge clk);

    // start re-pulsed mid-sweep is ignored.
    mode = 0;
    do_start(ONES_888, 48);
    repeat (9) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("t3_busy_after_repulse", busy, 1);
    check("t3_drv_after_repulse", drv, 3);
    wait_done("t3_done");

    // start in DONE clears state on the next edge.
    do_start(ONES_888, 48);
    check("t3_restart_done", done, 0);
    check("t3_restart_ones", ones, 0);
    check("t3_restart_drv", drv, 0);
    check("t3_restart_busy", busy, 1);

    // Async reset mid-sweep at drv=7.
    n = 0;
    while (drv !== 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach7", drv, 7);
    #2 rst = 1;
    #1;
    check("t4_drv", drv, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_ones", ones, 0);
    sq.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) rd(4'(i), 3'b000);
    @(negedge clk);

    // SETTLE=0 instance: a new pattern every cycle.
    do_start0(ONES_888, 16);
    for (int k = 0; k < 16; k++) begin
      check("t5_drv0", drv0, k);
      @(negedge clk);
    end
    check("t5_done0", done0, 1);

    repeat (3) @(negedge clk);
    check("sweeps_left", sq.size(), 0);
    check("sweeps0_left", sq0.size(), 0);
    check("reads_left", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
